// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared by the RISC-V pipeline stages.
//   XLEN      - datapath width
//   RESET_PC  - address of the first fetch after reset
//   NOP_INSTR - bubble instruction (addi x0,x0,0)
//   fetch_state_t - fetch FSM encoding (IDLE=0, REQ=1, WAIT=2, DROP=3)
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry holding buffer for an instruction that returned
// from memory while the IF/ID register was stalled.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   load                  - capture {load_instr, load_pc}
//   drain                 - entry consumed by IF/ID
//   clear                 - discard entry (redirect); wins over load/drain
//   valid, instr, pc      - buffered entry
module fetch_skid
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            drain,
  input  logic            clear,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);
  logic            r_valid;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
    end else if (clear) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_instr <= load_instr;
      r_pc    <= load_pc;
    end else if (drain) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign instr = r_instr;
  assign pc    = r_pc;
endmodule

// File: rtl/fetch.sv
// fetch: instruction-fetch stage. Owns the PC, issues one-outstanding
// fetches over a req/gnt/rvalid handshake (with back-to-back issue when a
// response returns), and holds the IF/ID register feeding decode.
// Ports:
//   clk, reset                    - clock, asynchronous active-high reset
//   imem_req/imem_addr (out)      - fetch request, held until imem_gnt
//   imem_gnt, imem_rvalid, imem_rdata (in) - memory handshake
//   PCTargetE, Branch_or_Jump_taken (in)   - redirect from execute
//   if_stall (in)                 - hold IF/ID and PC
//   instrD, PCD, PCPlus4D (out)   - IF/ID register
// Build option FETCH_PERF_EN adds perf_fetched / perf_bubbles counters.
module fetch
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic [31:0] PCTargetE,
  input  logic        Branch_or_Jump_taken,
  input  logic        if_stall,
  output logic [31:0] instrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);
  fetch_state_t    r_state, w_state_next;
  logic [XLEN-1:0] r_pc_f, w_pc_f_next;
  logic [XLEN-1:0] r_req_pc, w_req_pc_next;
  logic [XLEN-1:0] r_instr_d, r_pc_d, r_pc4_d;

  logic            w_skid_load, w_skid_drain, w_skid_clear, w_skid_valid;
  logic [XLEN-1:0] w_skid_instr, w_skid_pc;
  logic            w_rsp_to_ifid;   // response goes straight into IF/ID

  fetch_skid u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (w_skid_load),
    .drain      (w_skid_drain),
    .clear      (w_skid_clear),
    .load_instr (imem_rdata),
    .load_pc    (r_req_pc),
    .valid      (w_skid_valid),
    .instr      (w_skid_instr),
    .pc         (w_skid_pc)
  );

  always_comb begin
    w_state_next  = r_state;
    w_pc_f_next   = r_pc_f;
    w_req_pc_next = r_req_pc;
    imem_req      = 1'b0;
    imem_addr     = r_pc_f;
    w_skid_load   = 1'b0;
    w_rsp_to_ifid = 1'b0;
    case (r_state)
      IDLE: w_state_next = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          if (Branch_or_Jump_taken) begin
            w_state_next = DROP;   // granted fetch is on the flushed path
          end else begin
            w_req_pc_next = r_pc_f;
            w_pc_f_next   = r_pc_f + 32'd4;
            w_state_next  = WAIT;
          end
        end
      end
      WAIT: begin
        if (Branch_or_Jump_taken) begin
          // A same-cycle response is simply discarded, leaving nothing in flight.
          w_state_next = imem_rvalid ? REQ : DROP;
        end else if (imem_rvalid) begin
          if (if_stall) begin
            w_skid_load = 1'b1;    // stay in WAIT until the skid drains
          end else if (!w_skid_valid) begin
            w_rsp_to_ifid = 1'b1;
            imem_req      = 1'b1;  // back-to-back issue
            if (imem_gnt) begin
              w_req_pc_next = r_pc_f;
              w_pc_f_next   = r_pc_f + 32'd4;
            end else begin
              w_state_next = REQ;
            end
          end
        end else if (w_skid_valid && !if_stall) begin
          w_state_next = REQ;
        end
      end
      DROP: begin
        if (imem_rvalid) w_state_next = REQ;
      end
      default: w_state_next = IDLE;
    endcase
    if (Branch_or_Jump_taken) w_pc_f_next = PCTargetE;
  end

  assign w_skid_clear = Branch_or_Jump_taken;
  assign w_skid_drain = !Branch_or_Jump_taken && !if_stall && w_skid_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_pc_f   <= RESET_PC;
      r_req_pc <= RESET_PC;
    end else begin
      r_state  <= w_state_next;
      r_pc_f   <= w_pc_f_next;
      r_req_pc <= w_req_pc_next;
    end
  end

  // IF/ID: redirect > stall > skid > fresh response > bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr_d <= NOP_INSTR;
      r_pc_d    <= '0;
      r_pc4_d   <= '0;
    end else if (Branch_or_Jump_taken) begin
      r_instr_d <= NOP_INSTR;
      r_pc_d    <= '0;
      r_pc4_d   <= '0;
    end else if (!if_stall) begin
      if (w_skid_valid) begin
        r_instr_d <= w_skid_instr;
        r_pc_d    <= w_skid_pc;
        r_pc4_d   <= w_skid_pc + 32'd4;
      end else if (w_rsp_to_ifid) begin
        r_instr_d <= imem_rdata;
        r_pc_d    <= r_req_pc;
        r_pc4_d   <= r_req_pc + 32'd4;
      end else begin
        r_instr_d <= NOP_INSTR;
        r_pc_d    <= '0;
        r_pc4_d   <= '0;
      end
    end
  end

  assign instrD   = r_instr_d;
  assign PCD      = r_pc_d;
  assign PCPlus4D = r_pc4_d;

`ifdef FETCH_PERF_EN
  logic        w_load_instr, w_load_bubble;
  logic [31:0] r_perf_fetched, r_perf_bubbles;

  assign w_load_instr  = !Branch_or_Jump_taken && !if_stall && (w_skid_valid || w_rsp_to_ifid);
  assign w_load_bubble = Branch_or_Jump_taken ||
                         (!if_stall && !w_skid_valid && !w_rsp_to_ifid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_fetched <= '0;
      r_perf_bubbles <= '0;
    end else begin
      if (w_load_instr)  r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_load_bubble) r_perf_bubbles <= r_perf_bubbles + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_bubbles = r_perf_bubbles;
`endif
endmodule
